// File: rtl/asip_pkg.sv
// Shared ASIP datapath constants and the next-PC select encoding.
package asip_pkg;

   localparam int XLEN        = 32;
   localparam int INSTR_BYTES = 4;
   localparam logic [XLEN-1:0] RESET_VECTOR = '0;

   typedef enum logic {
      PC_SEL_SEQ = 1'b0,
      PC_SEL_JMP = 1'b1
   } pc_sel_t;

endpackage

// File: rtl/mux2.sv
// Generic 2:1 mux: o_y = i_sel ? i_b : i_a.
module mux2 #(
   parameter int WIDTH = 32
) (
   input  logic             i_sel,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_y
);

   assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/pc_register.sv
// WIDTH-bit register with asynchronous active-low reset to RESET_PC.
module pc_register #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_q <= RESET_PC;
      else          r_q <= i_d;
   end

   assign o_q = r_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, advancing by one word or loading a jump target.
module if_fetch_stage
   import asip_pkg::*;
#(
   parameter int               WIDTH    = XLEN,
   parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_VECTOR),
   parameter int               PC_INC   = INSTR_BYTES
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] jmp_pc,
   input  logic             pc_selector,
   output logic [WIDTH-1:0] pc
);

   pc_sel_t          w_sel;
   logic [WIDTH-1:0] w_pc_seq;
   logic [WIDTH-1:0] w_pc_next;

   assign w_sel = pc_sel_t'(pc_selector);

   // Unsigned, wraps modulo 2^WIDTH with no overflow indication.
   assign w_pc_seq = pc + WIDTH'(PC_INC);

   mux2 #(.WIDTH(WIDTH)) u_next_pc_mux (
      .i_sel (w_sel == PC_SEL_JMP),
      .i_a   (w_pc_seq),
      .i_b   (jmp_pc),
      .o_y   (w_pc_next)
   );

   pc_register #(.WIDTH(WIDTH), .RESET_PC(RESET_PC)) u_pc_reg (
      .i_clk   (clk),
      .i_rst_n (reset),
      .i_d     (w_pc_next),
      .o_q     (pc)
   );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed plus randomized checks of if_fetch_stage against an arithmetic PC model.
module tb_if_fetch_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] jmp_pc = 32'h0;
   logic        pc_selector = 1'b0;
   logic [31:0] pc;

   logic [31:0] m_pc;
   int          n_checks = 0;
   int          n_pass   = 0;

   if_fetch_stage dut (
      .clk         (clk),
      .reset       (reset),
      .jmp_pc      (jmp_pc),
      .pc_selector (pc_selector),
      .pc          (pc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Apply inputs, take one rising edge, update the model, check just after the edge.
   task automatic step(input logic sel, input logic [31:0] tgt, input string tag);
      pc_selector = sel;
      jmp_pc      = tgt;
      @(posedge clk);
      if (reset) m_pc = sel ? tgt : m_pc + 32'd4;
      else       m_pc = 32'h0;
      #1;
      check(tag, pc, m_pc);
   endtask

   initial begin
      m_pc = 32'h0;
      jmp_pc = 32'h1000;
      pc_selector = 1'b1;
      #1;
      check("reset_t0", pc, 32'h0);
      for (int i = 0; i < 3; i++) step(1'b1, 32'h1000, "reset_held");

      pc_selector = 1'b0;
      reset = 1'b1;
      step(1'b0, 32'h1000, "reset_release");
      check("release_is_4", pc, 32'h4);

      for (int i = 0; i < 4; i++) step(1'b0, 32'h0, "seq_fetch");
      check("seq_at_14", pc, 32'h14);

      step(1'b1, 32'h1000, "jump");
      check("jump_1000", pc, 32'h1000);
      step(1'b0, 32'h0, "after_jump_1");
      step(1'b0, 32'h0, "after_jump_2");
      check("at_1008", pc, 32'h1008);

      for (int i = 0; i < 3; i++) step(1'b1, 32'h1000, "repeat_jump");
      check("held_1000", pc, 32'h1000);
      step(1'b0, 32'h0, "repeat_then_seq");
      check("at_1004", pc, 32'h1004);

      step(1'b1, 32'hFFFF_FFFC, "jump_top");
      step(1'b0, 32'h0, "wrap");
      check("wrap_zero", pc, 32'h0);

      step(1'b1, 32'h0000_1003, "misaligned_jump");
      check("misaligned_verbatim", pc, 32'h1003);
      step(1'b0, 32'h0, "misaligned_seq");
      check("misaligned_plus4", pc, 32'h1007);

      step(1'b1, 32'h1000, "to_1000");
      step(1'b0, 32'h0, "to_1004");
      step(1'b0, 32'h0, "to_1008");
      check("pre_async_1008", pc, 32'h1008);
      #2;
      reset = 1'b0;
      m_pc = 32'h0;
      #1;
      check("async_reset_immediate", pc, 32'h0);
      step(1'b1, 32'h2000, "async_reset_held_jump");
      step(1'b0, 32'h0, "async_reset_held_seq");
      reset = 1'b1;
      step(1'b0, 32'h0, "async_release");
      check("async_release_4", pc, 32'h4);

      // Randomized traffic, including async reset pulses landing mid-cycle.
      for (int i = 0; i < 300; i++) begin
         logic        sel;
         logic [31:0] tgt;
         sel = ($urandom_range(0, 3) == 0);
         tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7))
                                           : $urandom;
         if ($urandom_range(0, 29) == 0) begin
            #2;
            reset = 1'b0;
            m_pc = 32'h0;
            #1;
            check("rand_async_reset", pc, 32'h0);
            step(sel, tgt, "rand_in_reset");
            reset = 1'b1;
         end
         step(sel, tgt, "rand_step");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/if_fetch_stage.md
Name:
if_fetch_stage

Overview:
- Instruction-fetch (IF) stage of the ASIP pipeline; owns the program counter (PC).
- Each clock edge the PC either advances sequentially by one instruction word or loads a jump/branch target supplied by later stages.
- The registered PC drives instruction-memory addressing and the IF/ID pipeline register.

Parameters:
- WIDTH, 32, bit width of the PC, the jump target and the adder datapath.
- RESET_PC, 0, PC value loaded while reset is asserted.
- PC_INC, 4, sequential increment in bytes (one 32-bit instruction).

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- jmp_pc  input  WIDTH  jump/branch target address.
- pc_selector  input  1  next-PC select: 0 = PC+PC_INC, 1 = jmp_pc.
- pc  output  WIDTH  current program counter, driven directly from the PC register.

Behaviour:
- Reset: when reset=0, pc is forced to RESET_PC immediately, independent of clk, and held for as long as reset stays low.
- Reset release: the first rising edge with reset=1 performs a normal update from RESET_PC.
- Next-PC mux: pc_next = pc_selector ? jmp_pc : (pc + PC_INC).
- Register update: on each rising clk edge with reset=1, pc <= pc_next.
- Latency: a change on pc_selector or jmp_pc affects pc at the next rising edge only. There is no combinational path from any input to pc.
- Arithmetic: the increment is unsigned, modulo 2^WIDTH. At the top address, 0xFFFFFFFC + 4 wraps to 0x00000000 and no overflow flag is produced.
- jmp_pc is loaded verbatim, with no alignment masking or checking. Misaligned targets are the caller's responsibility.
- pc_selector held at 1 for several cycles reloads jmp_pc every cycle, so pc stays at the target.
- Reset asserted mid-operation, including during a jump cycle, overrides everything: pc becomes RESET_PC asynchronously.
- There are no stall or enable inputs; the PC advances every cycle.
- No other state exists in the block.

Decomposition:
- Shared package (asip_pkg):
  - XLEN = 32.
  - INSTR_BYTES = 4.
  - RESET_VECTOR = 0.
  - Enum pc_sel_t, with PC_SEL_SEQ = 0 and PC_SEL_JMP = 1.
- Sub-modules:
  - pc_register: WIDTH-bit flop with asynchronous active-low reset to RESET_PC.
  - Generic 2:1 mux (mux2), reused elsewhere in the datapath.
  - The adder stays as an inline continuous assignment.

Test Plan:
- Reset: drive reset=0 with jmp_pc=0x1000 and pc_selector=1 while clk toggles -> pc=0x00000000 throughout. Release reset -> pc=0x4 after the first rising edge.
- Sequential fetch: from pc=0, pc_selector=0, 5 rising edges -> pc steps 0x4, 0x8, 0xC, 0x10, 0x14.
- Jump: at pc=0x14, pc_selector=1, jmp_pc=0x1000 for one edge -> pc=0x1000. With pc_selector=0, next two edges -> 0x1004, 0x1008.
- Repeated jump: pc_selector=1, jmp_pc=0x1000 held for 3 edges -> pc stays at 0x1000. Then pc_selector=0 -> 0x1004.
- Wrap-around: jump to 0xFFFFFFFC, then pc_selector=0 for one edge -> pc=0x00000000.
- Asynchronous reset mid-run: at pc=0x1008, pull reset low between clock edges -> pc=0x0 immediately, before the next edge. It stays at 0x0 until release.
